// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// mem_pkg : shared op encodings, FSM states and width defaults for the memory stage
// Rev 1.0
// ============================================================================
package mem_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;

  // Request op field is {pop, push, write, read}; exactly one bit may be set
  localparam logic [3:0] OP_READ  = 4'b0001;
  localparam logic [3:0] OP_WRITE = 4'b0010;
  localparam logic [3:0] OP_PUSH  = 4'b0100;
  localparam logic [3:0] OP_POP   = 4'b1000;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/data_ram.sv
`default_nettype none
// ============================================================================
// data_ram : DEPTH x DATA_W array, synchronous write, combinational read
// Rev 1.0
// ============================================================================
module data_ram
  import mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  // Contents are deliberately not reset
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
// data_memory_responder : valid/ready load/store/push/pop responder, fixed latency
// Rev 1.0
// ============================================================================
module data_memory_responder
  import mem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_read,
  input  logic              req_write,
  input  logic              req_push,
  input  logic              req_pop,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic [ADDR_W-1:0] sp
);

  localparam int                RAM_AW     = $clog2(DEPTH);
  localparam int                CNT_W      = 4;
  localparam logic [CNT_W-1:0]  c_last_cnt = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0]  c_cnt_one  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] c_sp_top   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] c_sp_one   = ADDR_W'(1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [3:0]          r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [ADDR_W-1:0]   r_sp;
  logic                r_resp_valid;
  logic                r_resp_err;
  logic [DATA_W-1:0]   r_resp_data;

  logic                w_accept;
  logic                w_commit;
  logic                w_err;
  logic                w_addr_ok;
  logic [ADDR_W-1:0]   w_sp_inc;
  logic [ADDR_W-1:0]   w_sp_dec;
  logic                w_ram_we;
  logic [RAM_AW-1:0]   w_ram_waddr;
  logic [RAM_AW-1:0]   w_ram_raddr;
  logic [DATA_W-1:0]   w_ram_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        w_accept  = req_valid;
        if (req_valid) begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (r_cnt == c_last_cnt) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Error decode on the captured request; any non-one-hot op falls to default
  always_comb begin
    w_addr_ok = (33'(r_addr) < 33'(DEPTH));
    w_sp_inc  = r_sp + c_sp_one;
    w_sp_dec  = r_sp - c_sp_one;
    case (r_op)
      OP_READ, OP_WRITE: w_err = !w_addr_ok;
      OP_PUSH:           w_err = (r_sp == '0);
      OP_POP:            w_err = (r_sp == c_sp_top);
      default:           w_err = 1'b1;
    endcase
    w_ram_we    = w_commit && !w_err && ((r_op == OP_WRITE) || (r_op == OP_PUSH));
    w_ram_waddr = (r_op == OP_PUSH) ? r_sp[RAM_AW-1:0] : r_addr[RAM_AW-1:0];
    w_ram_raddr = (r_op == OP_POP) ? w_sp_inc[RAM_AW-1:0] : r_addr[RAM_AW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt        <= '0;
      r_op         <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_sp         <= c_sp_top;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_data  <= '0;
      if (w_accept) begin
        r_op    <= {req_pop, req_push, req_write, req_read};
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_cnt   <= '0;
      end else if (r_state == ST_BUSY) begin
        r_cnt <= r_cnt + c_cnt_one;
      end
      if (w_commit) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= w_err;
        if (!w_err) begin
          if ((r_op == OP_READ) || (r_op == OP_POP)) begin
            r_resp_data <= w_ram_rdata;
          end
          if (r_op == OP_PUSH) begin
            r_sp <= w_sp_dec;
          end
          if (r_op == OP_POP) begin
            r_sp <= w_sp_inc;
          end
        end
      end
    end
  end

  data_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .waddr (w_ram_waddr),
    .wdata (r_wdata),
    .raddr (w_ram_raddr),
    .rdata (w_ram_rdata)
  );

  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_data  = r_resp_data;
  assign sp         = r_sp;

endmodule
`default_nettype wire
